alu_scheduler: RTL

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler_pkg.sv | 25 ++
 rtl/alu_scheduler_if.sv | 50 +++++
 rtl/alu_scheduler_rr_arbiter2.sv | 21 ++
 rtl/alu_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_scheduler_pkg.sv
// Shared opcode constants, FSM state encoding and SLT helper for the ALU scheduler.
package alu_scheduler_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Signed less-than from the sign bits of a subtraction a - b.
    function automatic logic slt_bit(input logic a_msb, input logic b_msb, input logic diff_msb);
        logic ovf;
        ovf = (a_msb != b_msb) && (diff_msb != a_msb);
        return diff_msb ^ ovf;
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester, shared-ALU and response signals of the ALU scheduler.
interface alu_scheduler_if #(
    parameter int unsigned WIDTH = 32
);

    logic                                req0_valid;
    logic                                req0_ready;
    logic [alu_scheduler_pkg::OP_W-1:0]  req0_op;
    logic [WIDTH-1:0]                    req0_a;
    logic [WIDTH-1:0]                    req0_b;

    logic                                req1_valid;
    logic                                req1_ready;
    logic [alu_scheduler_pkg::OP_W-1:0]  req1_op;
    logic [WIDTH-1:0]                    req1_a;
    logic [WIDTH-1:0]                    req1_b;

    logic [alu_scheduler_pkg::OP_W-1:0]  alu_op;
    logic [WIDTH-1:0]                    alu_a;
    logic [WIDTH-1:0]                    alu_b;
    logic [WIDTH-1:0]                    alu_result;
    logic                                alu_carry;

    logic                                resp_valid;
    logic                                resp_ready;
    logic                                resp_id;
    logic [WIDTH-1:0]                    resp_data;
    logic                                resp_carry;

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, alu_carry, resp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        output resp_valid, resp_id, resp_data, resp_carry
    );

    // Environment side: requesters, ALU and response consumer.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, alu_carry, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        input  resp_valid, resp_id, resp_data, resp_carry
    );

endinterface

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, tie goes to the requester not granted last.
module rr_arbiter2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant_c
);

    // Grant selection from current valids and last-grant pointer.
    always_comb begin
        grant_c = 2'b00;
        if (valid0 && valid1) begin
            grant_c = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant_c = 2'b01;
        end else if (valid1) begin
            grant_c = 2'b10;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Schedules two requesters onto one external ALU: IDLE (arbitrate) -> EXEC -> RESP.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_scheduler_if.slave     bus
);

    state_e            state_q;
    state_e            state_d;

    logic              last_grant_q;
    logic [1:0]        grant_c;
    logic              ready0_c;
    logic              ready1_c;
    logic              accept_c;

    logic [OP_W-1:0]   sel_op_c;
    logic [WIDTH-1:0]  sel_a_c;
    logic [WIDTH-1:0]  sel_b_c;

    logic [OP_W-1:0]   alu_op_q;
    logic [WIDTH-1:0]  alu_a_q;
    logic [WIDTH-1:0]  alu_b_q;
    logic              is_slt_q;
    logic              id_q;

    logic              resp_id_q;
    logic [WIDTH-1:0]  resp_data_q;
    logic              resp_carry_q;
    logic [WIDTH-1:0]  result_c;

    rr_arbiter2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .grant_c    (grant_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and request handshake; readys are held low while reset is asserted.
    always_comb begin
        state_d  = state_q;
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready0_c = grant_c[0] && !rst;
                ready1_c = grant_c[1] && !rst;
                accept_c = ready0_c || ready1_c;
                if (accept_c) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op_c = bus.req0_op;
        sel_a_c  = bus.req0_a;
        sel_b_c  = bus.req0_b;
        if (grant_c[1]) begin
            sel_op_c = bus.req1_op;
            sel_a_c  = bus.req1_a;
            sel_b_c  = bus.req1_b;
        end
    end

    // Capture the accepted request; SLT is executed on the ALU as a subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_q     <= OP_AND;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            is_slt_q     <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept_c) begin
            alu_op_q     <= (sel_op_c == OP_SLT) ? OP_SUB : sel_op_c;
            alu_a_q      <= sel_a_c;
            alu_b_q      <= sel_b_c;
            is_slt_q     <= (sel_op_c == OP_SLT);
            id_q         <= ready1_c;
            last_grant_q <= ready1_c;
        end
    end

    // Result selection: SLT reduces the difference to a single signed-compare bit.
    always_comb begin
        result_c = bus.alu_result;
        if (is_slt_q) begin
            result_c = WIDTH'(slt_bit(alu_a_q[WIDTH-1], alu_b_q[WIDTH-1], bus.alu_result[WIDTH-1]));
        end
    end

    // Capture the response at the end of EXEC; held unchanged through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
        end else if (state_q == EXEC) begin
            resp_id_q    <= id_q;
            resp_data_q  <= result_c;
            resp_carry_q <= bus.alu_carry;
        end
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_carry = resp_carry_q;

endmodule
